// File: rtl/led_pattern_engine_if.sv
// Switch-side controls and LED-side outputs of the LED pattern engine.
// The engine attaches through the slave modport; the driver of the switches uses master.
interface led_pattern_engine_if #(
  parameter int unsigned N_LED = 16
);
  logic [1:0]       speed;
  logic [1:0]       mode;
  logic             pause;
  logic [N_LED-1:0] led;
  logic             step;

  modport master (
    output speed, mode, pause,
    input  led, step
  );

  modport slave (
    input  speed, mode, pause,
    output led, step
  );
endinterface

// File: rtl/led_pattern_engine.sv
// LED bar pattern engine: chase-left, chase-right, bounce and fill at four speeds,
// stepped by an internal prescaler tick-enable, with an all-on INIT phase after reset.
module led_pattern_engine #(
  parameter int unsigned N_LED       = 16,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned PRE_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  led_pattern_engine_if.slave   io
);

  localparam int unsigned POS_W = $clog2(N_LED);
  localparam int unsigned LVL_W = $clog2(N_LED + 1);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_LED - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(N_LED);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    M_CHASE_L = 2'd0,
    M_CHASE_R = 2'd1,
    M_BOUNCE  = 2'd2,
    M_FILL    = 2'd3
  } mode_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] cnt_q,   cnt_d;
  logic [POS_W-1:0] pos_q,   pos_d;
  logic             dir_q,   dir_d;   // 0 = up, 1 = down (bounce only)
  logic [LVL_W-1:0] lvl_q,   lvl_d;
  logic [N_LED-1:0] led_q,   led_d;
  logic             step_q,  step_d;
  logic [1:0]       mode_q;
  logic [1:0]       speed_q;

  logic [PRE_W-1:0] period;
  logic             tick;
  logic             chg;
  mode_e            mode_cur;
  logic [POS_W-1:0] start_pos;
  logic [N_LED-1:0] start_led;
  logic [POS_W-1:0] next_pos;
  logic [LVL_W-1:0] next_lvl;

  function automatic logic [N_LED-1:0] onehot(input logic [POS_W-1:0] p);
    return N_LED'(1) << p;
  endfunction

  function automatic logic [N_LED-1:0] fill_bar(input logic [LVL_W-1:0] l);
    logic [N_LED-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      b[i] = (LVL_W'(i) < l);
    end
    return b;
  endfunction

  assign mode_cur = mode_e'(io.mode);
  assign period   = PRE_W'(BASE_PERIOD) << (2'd3 - io.speed);
  assign tick     = (cnt_q == period - PRE_W'(1)) && !io.pause;
  assign chg      = (io.mode != mode_q) || (io.speed != speed_q);

  // Start pattern for the mode currently on the switches.
  always_comb begin
    start_pos = '0;
    start_led = '0;
    case (mode_cur)
      M_CHASE_R: begin
        start_pos = LAST_POS;
        start_led = onehot(LAST_POS);
      end
      M_FILL: begin
        start_led = fill_bar(LVL_W'(1));
      end
      default: begin
        start_led = onehot('0);
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    lvl_d    = lvl_q;
    led_d    = led_q;
    step_d   = 1'b0;
    next_pos = pos_q;
    next_lvl = lvl_q;

    if (chg) begin
      // INIT only restarts its timer; RUN also reloads the start pattern, even while paused.
      cnt_d = '0;
      if (state_q == ST_RUN) begin
        pos_d = start_pos;
        dir_d = 1'b0;
        lvl_d = LVL_W'(1);
        led_d = start_led;
      end
    end else if (!io.pause) begin
      cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
      if (tick) begin
        step_d = 1'b1;
        if (state_q == ST_INIT) begin
          state_d = ST_RUN;
          pos_d   = start_pos;
          dir_d   = 1'b0;
          lvl_d   = LVL_W'(1);
          led_d   = start_led;
        end else begin
          case (mode_cur)
            M_CHASE_L: begin
              next_pos = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
              pos_d    = next_pos;
              led_d    = onehot(next_pos);
            end
            M_CHASE_R: begin
              next_pos = (pos_q == '0) ? LAST_POS : pos_q - POS_W'(1);
              pos_d    = next_pos;
              led_d    = onehot(next_pos);
            end
            M_BOUNCE: begin
              // Reverse on arrival so each endpoint is shown for a single step.
              if (!dir_q) begin
                next_pos = pos_q + POS_W'(1);
                if (next_pos == LAST_POS) dir_d = 1'b1;
              end else begin
                next_pos = pos_q - POS_W'(1);
                if (next_pos == '0) dir_d = 1'b0;
              end
              pos_d = next_pos;
              led_d = onehot(next_pos);
            end
            default: begin
              next_lvl = (lvl_q == FULL_LVL) ? '0 : lvl_q + LVL_W'(1);
              lvl_d    = next_lvl;
              led_d    = fill_bar(next_lvl);
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      lvl_q   <= '0;
      led_q   <= '1;
      step_q  <= 1'b0;
      mode_q  <= io.mode;
      speed_q <= io.speed;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      lvl_q   <= lvl_d;
      led_q   <= led_d;
      step_q  <= step_d;
      mode_q  <= io.mode;
      speed_q <= io.speed;
    end
  end

  assign io.led  = led_q;
  assign io.step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (N_LED=8, BASE_PERIOD=4): the stimulus process
// queues the expected led/step per edge from a step-index reference model; a monitor compares.
module tb_led_pattern_engine;

  localparam int unsigned N    = 8;
  localparam int unsigned BASE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  led_pattern_engine_if #(.N_LED(N)) bus ();

  led_pattern_engine #(
    .N_LED       (N),
    .BASE_PERIOD (BASE),
    .PRE_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  led;
    logic        step;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_cnt  = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: phase, cycles elapsed in the current step, step index within the pattern.
  bit          m_run;
  int unsigned m_e;
  int unsigned m_k;
  logic [1:0]  m_pmode, m_pspeed;
  logic [7:0]  m_led;
  logic        m_step;

  function automatic logic [7:0] pattern(input int unsigned m, input int unsigned k);
    int unsigned j, l;
    logic [7:0]  r;
    case (m)
      0: r = 8'(1 << (k % N));
      1: r = 8'(1 << (N - 1 - (k % N)));
      2: begin
        j = k % (2 * N - 2);
        r = (j < N) ? 8'(1 << j) : 8'(1 << (2 * N - 2 - j));
      end
      default: begin
        l = (k + 1) % (N + 1);
        r = 8'((1 << l) - 1);
      end
    endcase
    return r;
  endfunction

  task automatic model_edge(input bit r, input logic [1:0] m, input logic [1:0] s, input bit p);
    int unsigned per;
    bit          changed;
    per = BASE << (3 - s);
    if (r) begin
      m_run  = 0;
      m_e    = 0;
      m_led  = 8'hFF;
      m_step = 1'b0;
    end else begin
      changed = (m != m_pmode) || (s != m_pspeed);
      m_step  = 1'b0;
      if (changed) begin
        m_e = 0;
        if (m_run) begin
          m_k   = 0;
          m_led = pattern(m, 0);
        end
      end else if (!p) begin
        if (m_e == per - 1) begin
          m_e    = 0;
          m_step = 1'b1;
          if (!m_run) begin
            m_run = 1;
            m_k   = 0;
          end else begin
            m_k = m_k + 1;
          end
          m_led = pattern(m, m_k);
        end else begin
          m_e = m_e + 1;
        end
      end
    end
    m_pmode  = m;
    m_pspeed = s;
  endtask

  task automatic drive(input bit r, input logic [1:0] m, input logic [1:0] s, input bit p);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    bus.mode  = m;
    bus.speed = s;
    bus.pause = p;
    model_edge(r, m, s, p);
    e.cyc  = cyc_cnt + 1;
    e.led  = m_led;
    e.step = m_step;
    sb.push_back(e);
  endtask

  task automatic run(input int unsigned n, input bit r, input logic [1:0] m,
                     input logic [1:0] s, input bit p);
    for (int unsigned i = 0; i < n; i++) drive(r, m, s, p);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (bus.led !== e.led || bus.step !== e.step) begin
        failures = failures + 1;
        $display("FAIL led_step cyc=%0d: got led=%02h step=%b, expected led=%02h step=%b",
                 e.cyc, bus.led, bus.step, e.led, e.step);
      end
    end
  end

  logic rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rst_seen) begin
      checks = checks + 1;
      if (bus.led !== 8'hFF || bus.step !== 1'b0) begin
        failures = failures + 1;
        $display("FAIL reset_state cyc=%0d: got led=%02h step=%b, expected led=ff step=0",
                 cyc_cnt, bus.led, bus.step);
      end
    end
  end

  initial begin
    logic [1:0]  rm, rs;
    bit          rp;
    int unsigned wait_cyc;
    bus.mode  = 2'd0;
    bus.speed = 2'd3;
    bus.pause = 1'b0;

    // Chase-left from reset, including the wrap from 0x80 back to 0x01.
    run(1, 1, 2'd0, 2'd3, 0);
    run(40, 0, 2'd0, 2'd3, 0);
    // Bounce through both endpoints.
    run(1, 1, 2'd2, 2'd3, 0);
    run(70, 0, 2'd2, 2'd3, 0);
    // Fill through all-on, all-off and back to one.
    run(1, 1, 2'd3, 2'd3, 0);
    run(46, 0, 2'd3, 2'd3, 0);
    // Speed change at led=0x08, then a mode change.
    run(1, 1, 2'd0, 2'd3, 0);
    run(17, 0, 2'd0, 2'd3, 0);
    run(40, 0, 2'd0, 2'd0, 0);
    run(10, 0, 2'd1, 2'd0, 0);
    // Pause mid-step, release, and a mode change while paused.
    run(1, 1, 2'd0, 2'd3, 0);
    run(6, 0, 2'd0, 2'd3, 0);
    run(10, 0, 2'd0, 2'd3, 1);
    run(12, 0, 2'd0, 2'd3, 0);
    run(3, 0, 2'd2, 2'd3, 1);
    run(10, 0, 2'd2, 2'd3, 0);
    // Reset mid-step in chase-right, then a full INIT.
    run(1, 1, 2'd1, 2'd3, 0);
    run(10, 0, 2'd1, 2'd3, 0);
    run(1, 1, 2'd1, 2'd3, 0);
    run(12, 0, 2'd1, 2'd3, 0);
    // INIT restart on a speed change.
    run(1, 1, 2'd0, 2'd3, 0);
    run(2, 0, 2'd0, 2'd3, 0);
    run(8, 0, 2'd0, 2'd2, 0);

    // Randomized mix of mode/speed/pause changes with occasional resets.
    rm = 2'd0;
    rs = 2'd3;
    rp = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) rp = !rp;
      drive($urandom_range(0, 299) == 0, rm, rs, rp);
    end

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #6;
    checks = checks + 1;
    if (sb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain_timeout: %0d expectations still pending after %0d cycles",
               sb.size(), wait_cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor of the two-speed single-LED chaser. Drives an N_LED-wide LED bar from one system clock, using an internal prescaler tick-enable. No derived clocks.
- Four speed levels, four pattern modes (chase-left, chase-right, bounce, fill) and a pause input.
- An all-on INIT phase runs after reset. The pattern restarts on any mode or speed change.
- Sits between the board switches and the LED pins in the lab top level.

Parameters:
N_LED, 16, number of LEDs driven (legal range 2..32).
BASE_PERIOD, 25_000_000, step period in clk cycles at the fastest speed (speed=3). Must be >= 1.
PRE_W, 32, prescaler counter width. Must hold BASE_PERIOD*8-1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
speed  input  2  step period P = BASE_PERIOD << (3 - speed). speed=0 is slowest (8x), speed=3 is fastest (1x).
mode  input  2  0 = chase-left, 1 = chase-right, 2 = bounce, 3 = fill.
pause  input  1  1 = freeze prescaler and pattern.
led  output  N_LED  registered LED drive.
step  output  1  registered one-cycle pulse, high in the same cycle led takes its new step value.

Behaviour:
- Single clock domain. All outputs are registered. Priority per clk edge: rst > change > pause > tick.
- Reset (rst=1 at an edge):
  - led = all ones, step = 0, state = INIT, cnt = 0, pos = 0, dir = up, level = 0.
  - mode_q <= mode, speed_q <= speed.
- Prescaler:
  - tick = (cnt == P-1) && !pause.
  - On tick, cnt <= 0; else if !pause, cnt <= cnt+1; else cnt holds.
  - One step lasts exactly P cycles of non-paused time.
- Change detect: chg = (mode != mode_q) || (speed != speed_q). mode_q and speed_q update every non-reset edge.
- States: INIT and RUN.
  - INIT: led held all ones. On tick: state <= RUN, led <= start pattern of the current mode, step <= 1. INIT therefore lasts P cycles after reset release, plus any paused time.
  - INIT with chg: cnt <= 0 and the state stays INIT. The INIT period restarts at the new P.
  - RUN with chg: cnt <= 0, led <= start pattern of the new mode, internal position reset, step <= 0. This takes effect even while paused. led shows the new start pattern one cycle after the input change.
  - RUN with tick: advance the pattern, step <= 1. Otherwise step <= 0 and led holds.
- Start patterns and advance rules (bit0 = LSB):
  - mode 0, chase-left: start pos = 0 (led = 1<<0). Advance pos = pos+1, wrapping N_LED-1 -> 0. Exactly one bit lit.
  - mode 1, chase-right: start pos = N_LED-1. Advance pos = pos-1, wrapping 0 -> N_LED-1.
  - mode 2, bounce: start pos = 0, dir = up.
    - Going up: pos+1; at N_LED-1, reverse to down.
    - Going down: pos-1; at 0, reverse to up.
    - Each endpoint is shown for one step only. The cycle length is 2*N_LED-2 steps.
  - mode 3, fill: start level = 1. led = (1<<level)-1, so low 'level' bits are lit.
    - Advance level+1 up to N_LED (all on).
    - The next step goes to level 0 (all off), then 1. The cycle length is N_LED+1 steps.
- pause:
  - cnt, state and pattern freeze; step = 0.
  - Deasserting pause resumes counting from the frozen cnt. The partial step is not lost.
- Width rules:
  - pos width is clog2(N_LED). level width is clog2(N_LED+1).
  - P is computed in PRE_W bits with no overflow within the legal parameter range.
- Reset mid-operation: returns led to all ones on the next edge from any state or mode. It clears any in-flight step pulse.

Test Plan:
All scenarios use N_LED=8 and BASE_PERIOD=4, so speed=3 gives P=4 and speed=0 gives P=32.
1. Reset, then mode=0, speed=3 -> led=0xFF for 4 cycles, then 0x01, 0x02, ... 0x80, 0x01, each held 4 cycles, with step pulsing on each change.
2. mode=2, speed=3 from reset -> after INIT: 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02. The 80 and 01 endpoints each last one step.
3. mode=3, speed=3 -> after INIT: 01,03,07,0F,1F,3F,7F,FF,00,01.
4. Running mode=0 at led=0x08, switch speed 3->0 -> next cycle led=0x01, then 0x02 after 32 cycles. Switch mode to 1 -> next cycle led=0x80.
5. pause=1 for 10 cycles at cnt=2 of a step -> led and step are frozen. After release, the step completes in 2 more cycles (cnt 2->3, then advance).
6. rst=1 for 1 cycle in mode 1 mid-step -> led=0xFF and step=0 on the next edge, then a full INIT of P cycles before 0x80.
